// File: rtl/mem_req_arbiter_pkg.sv
// Shared request encoding for the memory request path.
// Covers command codes, address/data widths and the 88-bit FIFO entry layout.
package mem_req_arbiter_pkg;

   localparam int unsigned ADDR_W = 22;
   localparam int unsigned DATA_W = 64;

   typedef enum logic [1:0] {
      CmdNoop    = 2'd0,
      CmdRefresh = 2'd1,
      CmdRead    = 2'd2,
      CmdWrite   = 2'd3
   } cmd_e;

   typedef struct packed {
      cmd_e              cmd;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] dta;
   } mem_req_t;

   typedef enum logic {
      RrMc = 1'b0,
      RrFs = 1'b1
   } rr_e;

endpackage

// File: rtl/mem_req_arbiter_if.sv
// Client request handshakes and the controller-facing request read port.
// The master modport is the arbiter's view; the slave modport is the clients' and controller's view.
interface mem_req_arbiter_if;
   import mem_req_arbiter_pkg::*;

   logic              disp_rd_valid;
   logic [ADDR_W-1:0] disp_rd_addr;
   logic              disp_rd_ready;
   logic              mc_rd_valid;
   logic [ADDR_W-1:0] mc_rd_addr;
   logic              mc_rd_ready;
   logic              fs_wr_valid;
   logic [ADDR_W-1:0] fs_wr_addr;
   logic [DATA_W-1:0] fs_wr_dta;
   logic              fs_wr_ready;
   logic              mem_req_rd_en;
   logic [1:0]        mem_req_rd_cmd;
   logic [ADDR_W-1:0] mem_req_rd_addr;
   logic [DATA_W-1:0] mem_req_rd_dta;
   logic              mem_req_rd_valid;
   logic              refresh_missed;

   modport master (
      input  disp_rd_valid, disp_rd_addr, mc_rd_valid, mc_rd_addr,
      input  fs_wr_valid, fs_wr_addr, fs_wr_dta, mem_req_rd_en,
      output disp_rd_ready, mc_rd_ready, fs_wr_ready,
      output mem_req_rd_cmd, mem_req_rd_addr, mem_req_rd_dta, mem_req_rd_valid,
      output refresh_missed
   );

   modport slave (
      output disp_rd_valid, disp_rd_addr, mc_rd_valid, mc_rd_addr,
      output fs_wr_valid, fs_wr_addr, fs_wr_dta, mem_req_rd_en,
      input  disp_rd_ready, mc_rd_ready, fs_wr_ready,
      input  mem_req_rd_cmd, mem_req_rd_addr, mem_req_rd_dta, mem_req_rd_valid,
      input  refresh_missed
   );

endinterface

// File: rtl/mem_req_arbiter_fifo.sv
// Synchronous request FIFO with a registered read port and no write-to-read bypass.
// The read port holds its last data when no read occurs.
module mem_req_arbiter_fifo
   import mem_req_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wr_en_i,
   input  mem_req_t            wr_data_i,
   input  logic                rd_en_i,
   output mem_req_t            rd_data_o,
   output logic                rd_valid_o,
   output logic                full_o,
   output logic                empty_o,
   output logic [ADDR_WIDTH:0] count_o
);

   localparam int unsigned Depth = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] PtrOne = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH:0]   CntOne = (ADDR_WIDTH + 1)'(1);
   localparam logic [ADDR_WIDTH:0]   CntFull = (ADDR_WIDTH + 1)'(Depth);

   mem_req_t                mem_q [Depth];
   logic [ADDR_WIDTH-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
   logic [ADDR_WIDTH:0]     count_q, count_d;
   mem_req_t                rd_data_q;
   logic                    rd_valid_q;
   logic                    wr, rd;

   assign full_o     = (count_q == CntFull);
   assign empty_o    = (count_q == '0);
   assign count_o    = count_q;
   assign rd_data_o  = rd_data_q;
   assign rd_valid_o = rd_valid_q;

   // Full/empty come from the registered count, so a read never sees this cycle's write.
   assign wr = wr_en_i & ~full_o;
   assign rd = rd_en_i & ~empty_o;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (wr) wptr_d = wptr_q + PtrOne;
      if (rd) rptr_d = rptr_q + PtrOne;
      unique case ({wr, rd})
         2'b10:   count_d = count_q + CntOne;
         2'b01:   count_d = count_q - CntOne;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (wr) mem_q[wptr_q] <= wr_data_i;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         count_q    <= count_d;
         rd_valid_q <= rd;
         if (rd) rd_data_q <= mem_q[rptr_q];
      end
   end

endmodule

// File: rtl/mem_req_arbiter.sv
// Arbitrates refresh, display, motion-comp and framestore requests into the request FIFO.
// Priority: pending refresh, then display, then MC/FS round-robin.
module mem_req_arbiter
   import mem_req_arbiter_pkg::*;
#(
   parameter int unsigned FIFO_ADDR_WIDTH  = 4,
   parameter int unsigned REFRESH_INTERVAL = 780
) (
   input logic               clk,
   input logic               rst,
   mem_req_arbiter_if.master req_io
);

   localparam int unsigned CntW = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
   localparam logic [CntW-1:0] Reload = CntW'(REFRESH_INTERVAL - 1);
   localparam logic [CntW-1:0] CntOne = CntW'(1);
   localparam logic [FIFO_ADDR_WIDTH:0] DepthCnt = (FIFO_ADDR_WIDTH + 1)'(2 ** FIFO_ADDR_WIDTH);

   logic [CntW-1:0]          ref_cnt_q, ref_cnt_d;
   logic                     pend_q, pend_d;
   rr_e                      rr_q, rr_d;
   logic                     expire, can_grant;
   logic                     g_ref, g_disp, g_mc, g_fs;
   mem_req_t                 wr_req, rd_req;
   logic                     fifo_wr, fifo_full, fifo_empty, fifo_rd_valid;
   logic [FIFO_ADDR_WIDTH:0] fifo_count;

   always_comb begin
      expire    = (ref_cnt_q == '0);
      ref_cnt_d = expire ? Reload : ref_cnt_q - CntOne;
      can_grant = rst & ~fifo_full;
      g_ref     = 1'b0;
      g_disp    = 1'b0;
      g_mc      = 1'b0;
      g_fs      = 1'b0;
      if (can_grant) begin
         if (pend_q) begin
            g_ref = 1'b1;
         end else if (req_io.disp_rd_valid) begin
            g_disp = 1'b1;
         end else if (req_io.mc_rd_valid && req_io.fs_wr_valid) begin
            if (rr_q == RrFs) g_fs = 1'b1;
            else              g_mc = 1'b1;
         end else if (req_io.mc_rd_valid) begin
            g_mc = 1'b1;
         end else if (req_io.fs_wr_valid) begin
            g_fs = 1'b1;
         end
      end

      // An expiry in the same cycle as the refresh enqueue re-arms the request.
      pend_d = expire | (pend_q & ~g_ref);

      rr_d = rr_q;
      if (g_mc)      rr_d = RrFs;
      else if (g_fs) rr_d = RrMc;

      fifo_wr = g_ref | g_disp | g_mc | g_fs;
      wr_req  = '0;
      if (g_ref) begin
         wr_req.cmd = CmdRefresh;
      end else if (g_disp) begin
         wr_req.cmd  = CmdRead;
         wr_req.addr = req_io.disp_rd_addr;
      end else if (g_mc) begin
         wr_req.cmd  = CmdRead;
         wr_req.addr = req_io.mc_rd_addr;
      end else if (g_fs) begin
         wr_req.cmd  = CmdWrite;
         wr_req.addr = req_io.fs_wr_addr;
         wr_req.dta  = req_io.fs_wr_dta;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         ref_cnt_q <= Reload;
         pend_q    <= 1'b0;
         rr_q      <= RrMc;
      end else begin
         ref_cnt_q <= ref_cnt_d;
         pend_q    <= pend_d;
         rr_q      <= rr_d;
      end
   end

   mem_req_arbiter_fifo #(
      .ADDR_WIDTH (FIFO_ADDR_WIDTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .wr_en_i    (fifo_wr),
      .wr_data_i  (wr_req),
      .rd_en_i    (req_io.mem_req_rd_en & ~fifo_empty),
      .rd_data_o  (rd_req),
      .rd_valid_o (fifo_rd_valid),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty),
      .count_o    (fifo_count)
   );

   assert property (@(posedge clk) disable iff (!rst) fifo_count <= DepthCnt);

   assign req_io.disp_rd_ready    = g_disp;
   assign req_io.mc_rd_ready      = g_mc;
   assign req_io.fs_wr_ready      = g_fs;
   assign req_io.refresh_missed   = rst & expire & pend_q;
   assign req_io.mem_req_rd_cmd   = rd_req.cmd;
   assign req_io.mem_req_rd_addr  = rd_req.addr;
   assign req_io.mem_req_rd_dta   = rd_req.dta;
   assign req_io.mem_req_rd_valid = fifo_rd_valid;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Randomized bench for mem_req_arbiter against a queue-based reference model.
// Refresh timing in the model is derived from the cycle index since reset release.
module tb_mem_req_arbiter;
   import mem_req_arbiter_pkg::*;

   localparam int unsigned RI  = 8;
   localparam int unsigned FAW = 4;
   localparam int unsigned Depth = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_req_arbiter_if bus_if ();

   mem_req_arbiter #(
      .FIFO_ADDR_WIDTH  (FAW),
      .REFRESH_INTERVAL (RI)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .req_io (bus_if)
   );

   typedef struct {
      logic [1:0]  cmd;
      logic [21:0] addr;
      logic [63:0] dta;
   } ent_t;

   int n_checks = 0;
   int n_fail   = 0;

   // Client stimulus state
   bit          c_valid [3];
   logic [21:0] c_addr  [3];
   logic [63:0] c_dta;
   bit          rnd_mode;
   int unsigned pct;

   // Reference model state
   ent_t        q [$];
   ent_t        exp_out;
   bit          exp_valid;
   bit          pend;
   bit          rr_fs;
   int unsigned cyc;
   bit          m_rdy [3];

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic apply_inputs();
      bus_if.disp_rd_valid = c_valid[0];
      bus_if.disp_rd_addr  = c_addr[0];
      bus_if.mc_rd_valid   = c_valid[1];
      bus_if.mc_rd_addr    = c_addr[1];
      bus_if.fs_wr_valid   = c_valid[2];
      bus_if.fs_wr_addr    = c_addr[2];
      bus_if.fs_wr_dta     = c_dta;
   endtask

   task automatic drive_clients();
      if (rnd_mode) begin
         for (int i = 0; i < 3; i++) begin
            if (!c_valid[i] || m_rdy[i]) begin
               c_valid[i] = ($urandom_range(0, 99) < pct);
               c_addr[i]  = 22'($urandom);
               if (i == 2) c_dta = {$urandom, $urandom};
            end
         end
      end
      apply_inputs();
   endtask

   // Compare the current cycle, then advance the model across the coming edge.
   task automatic model_cycle();
      bit   rdy [3];
      bit   refr, missed, full, expire, rd;
      ent_t e;
      rdy    = '{1'b0, 1'b0, 1'b0};
      refr   = 1'b0;
      missed = 1'b0;
      expire = 1'b0;
      if (rst) begin
         full   = (q.size() >= Depth);
         expire = ((cyc % RI) == RI - 1);
         missed = expire && pend;
         if (!full) begin
            if (pend)                                     refr = 1'b1;
            else if (bus_if.disp_rd_valid)                rdy[0] = 1'b1;
            else if (bus_if.mc_rd_valid && bus_if.fs_wr_valid) begin
               if (rr_fs) rdy[2] = 1'b1;
               else       rdy[1] = 1'b1;
            end
            else if (bus_if.mc_rd_valid)                  rdy[1] = 1'b1;
            else if (bus_if.fs_wr_valid)                  rdy[2] = 1'b1;
         end
      end

      check_val("disp_ready", 64'(bus_if.disp_rd_ready), 64'(rdy[0]));
      check_val("mc_ready", 64'(bus_if.mc_rd_ready), 64'(rdy[1]));
      check_val("fs_ready", 64'(bus_if.fs_wr_ready), 64'(rdy[2]));
      check_val("refresh_missed", 64'(bus_if.refresh_missed), 64'(missed));
      check_val("rd_valid", 64'(bus_if.mem_req_rd_valid), 64'(exp_valid));
      check_val("rd_cmd", 64'(bus_if.mem_req_rd_cmd), 64'(exp_out.cmd));
      check_val("rd_addr", 64'(bus_if.mem_req_rd_addr), 64'(exp_out.addr));
      check_val("rd_dta", bus_if.mem_req_rd_dta, exp_out.dta);

      if (!rst) begin
         q.delete();
         exp_valid = 1'b0;
         exp_out   = '{cmd: 2'd0, addr: 22'd0, dta: 64'd0};
         pend      = 1'b0;
         rr_fs     = 1'b0;
         cyc       = 0;
      end else begin
         rd        = bus_if.mem_req_rd_en && (q.size() > 0);
         exp_valid = rd;
         if (rd) exp_out = q.pop_front();
         if (refr) begin
            e = '{cmd: 2'd1, addr: 22'd0, dta: 64'd0};
            q.push_back(e);
         end else if (rdy[0]) begin
            e = '{cmd: 2'd2, addr: bus_if.disp_rd_addr, dta: 64'd0};
            q.push_back(e);
         end else if (rdy[1]) begin
            e = '{cmd: 2'd2, addr: bus_if.mc_rd_addr, dta: 64'd0};
            q.push_back(e);
            rr_fs = 1'b1;
         end else if (rdy[2]) begin
            e = '{cmd: 2'd3, addr: bus_if.fs_wr_addr, dta: bus_if.fs_wr_dta};
            q.push_back(e);
            rr_fs = 1'b0;
         end
         if (expire)    pend = 1'b1;
         else if (refr) pend = 1'b0;
         cyc++;
      end
      m_rdy = rdy;
   endtask

   task automatic run(input int n);
      repeat (n) begin
         @(negedge clk);
         model_cycle();
         @(posedge clk);
         #1;
         drive_clients();
      end
   endtask

   initial begin
      rst                  = 1'b0;
      bus_if.mem_req_rd_en = 1'b0;
      rnd_mode             = 1'b0;
      pct                  = 0;
      c_dta                = '0;
      for (int i = 0; i < 3; i++) begin
         c_valid[i] = 1'b0;
         c_addr[i]  = '0;
         m_rdy[i]   = 1'b0;
      end
      exp_valid = 1'b0;
      exp_out   = '{cmd: 2'd0, addr: 22'd0, dta: 64'd0};
      pend      = 1'b0;
      rr_fs     = 1'b0;
      cyc       = 0;
      apply_inputs();
      @(posedge clk);
      #1;
      run(3);

      // Idle clients: periodic refreshes only
      rst                  = 1'b1;
      bus_if.mem_req_rd_en = 1'b1;
      run(30);

      // All clients held: display dominates, then MC/FS alternate
      c_valid   = '{1'b1, 1'b1, 1'b1};
      c_addr[0] = 22'h000010;
      c_addr[1] = 22'h000020;
      c_addr[2] = 22'h000030;
      c_dta     = 64'hDEAD_BEEF_0000_0001;
      apply_inputs();
      run(12);
      c_valid[0] = 1'b0;
      apply_inputs();
      run(20);
      c_valid = '{1'b0, 1'b0, 1'b0};
      apply_inputs();
      run(20);

      // Fill the FIFO with writes, let refreshes go missed, then drain
      bus_if.mem_req_rd_en = 1'b0;
      c_valid[2] = 1'b1;
      apply_inputs();
      run(24);
      bus_if.mem_req_rd_en = 1'b1;
      run(1);
      bus_if.mem_req_rd_en = 1'b0;
      run(6);
      c_valid[2] = 1'b0;
      apply_inputs();
      bus_if.mem_req_rd_en = 1'b1;
      run(30);

      // Random traffic, light then heavy
      rnd_mode = 1'b1;
      pct      = 40;
      repeat (400) begin
         bus_if.mem_req_rd_en = 1'($urandom_range(0, 1));
         run(1);
      end
      pct = 85;
      repeat (200) begin
         bus_if.mem_req_rd_en = ($urandom_range(0, 9) < 3);
         run(1);
      end

      // Reset with entries queued discards them
      bus_if.mem_req_rd_en = 1'b0;
      run(8);
      rst = 1'b0;
      run(1);
      rst                  = 1'b1;
      bus_if.mem_req_rd_en = 1'b1;
      run(30);

      rnd_mode = 1'b0;
      c_valid  = '{1'b0, 1'b0, 1'b0};
      apply_inputs();
      run(30);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
